// File: rtl/qbus_dma_master.sv
// qbus_dma_master
// Single-word QBUS bus master. Arbitrates for the bus with DMR/DMG/SACK, then
// runs one DATI (read) or DATO (write) cycle with programmable address setup,
// data setup and RPLY-to-latch delay. A missing grant or a missing RPLY
// is reported as NXM after NXM_TO clocks.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   req, we, addr, wdata       host request, captured in IDLE only
//   ack, nxm, rdata            completion pulse, NXM flag (valid with ack),
//                              last latched read data
//   DAL, DALtx                 shared address/data lines, driver enable
//   RSYNC, RRPLY, RDMGI, RINIT bus receivers (active-high)
//   TDMR, TSACK, TDMGO, TSYNC,
//   TDIN, TDOUT, TBS7, TWTBT   bus drivers (active-high, registered)
//
// Build option: define QDMA_HOLD_EN to keep bus ownership (TSACK) when a new
// req is present in the ack clock, skipping arbitration; up to 4 transfers
// per bus tenure. Without it every transfer arbitrates from ARB.

module qbus_dma_master #(
  parameter int unsigned ADDR_SETUP = 15,
  parameter int unsigned DATA_SETUP = 10,
  parameter int unsigned RPLY_DLY   = 15,
  parameter int unsigned NXM_TO     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [21:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic        nxm,
  output logic [15:0] rdata,
  inout  wire  [21:0] DAL,
  output logic        DALtx,
  input  logic        RSYNC,
  input  logic        RRPLY,
  input  logic        RDMGI,
  input  logic        RINIT,
  output logic        TDMR,
  output logic        TSACK,
  output logic        TDMGO,
  output logic        TSYNC,
  output logic        TDIN,
  output logic        TDOUT,
  output logic        TBS7,
  output logic        TWTBT
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_WAITBUS, S_ADDR, S_ASYNC,
    S_RD, S_RDLY, S_WR, S_DOUT, S_FIN, S_REL
  } state_t;

  // Terminal counts: a state that must last N clocks leaves when r_cnt == N-1.
  localparam logic [15:0] L_ADDR_LAST = 16'(ADDR_SETUP - 1);
  localparam logic [15:0] L_DATA_LAST = 16'(DATA_SETUP - 1);
  localparam logic [15:0] L_RDLY_LAST = 16'(RPLY_DLY - 1);
  localparam logic [15:0] L_NXM_LAST  = 16'(NXM_TO - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_flag;      // NXM seen during this transfer
  logic        r_we;
  logic [21:1] r_addr;
  logic [15:0] r_wdata;
  logic [21:0] r_dal_out;
  logic [15:0] r_rdata;
  logic        r_ack;
  logic        r_nxm;
  logic        r_daltx;
  logic        r_tdmr;
  logic        r_tsack;
  logic        r_tdmgo;
  logic        r_tsync;
  logic        r_tdin;
  logic        r_tdout;
  logic        r_tbs7;
  logic        r_twtbt;
`ifdef QDMA_HOLD_EN
  logic [2:0]  r_hold_cnt;  // transfers completed in the current bus tenure
`endif

  logic [15:0] w_cnt_inc;
  logic        w_unused;

  // Counter saturates at all ones instead of wrapping.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 16'd1;

  // Byte address bit 0 is never put on DAL; DAL[21:16] is not read back.
  assign w_unused = ^{addr[0], DAL[21:16]};

  assign DAL   = r_daltx ? r_dal_out : 'z;
  assign ack   = r_ack;
  assign nxm   = r_nxm;
  assign rdata = r_rdata;
  assign DALtx = r_daltx;
  assign TDMR  = r_tdmr;
  assign TSACK = r_tsack;
  assign TDMGO = r_tdmgo;
  assign TSYNC = r_tsync;
  assign TDIN  = r_tdin;
  assign TDOUT = r_tdout;
  assign TBS7  = r_tbs7;
  assign TWTBT = r_twtbt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_flag    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_dal_out <= '0;
      r_rdata   <= '0;
      r_ack     <= 1'b0;
      r_nxm     <= 1'b0;
      r_daltx   <= 1'b0;
      r_tdmr    <= 1'b0;
      r_tsack   <= 1'b0;
      r_tdmgo   <= 1'b0;
      r_tsync   <= 1'b0;
      r_tdin    <= 1'b0;
      r_tdout   <= 1'b0;
      r_tbs7    <= 1'b0;
      r_twtbt   <= 1'b0;
`ifdef QDMA_HOLD_EN
      r_hold_cnt <= '0;
`endif
    end else if (RINIT) begin
      // Bus init aborts whatever is in flight; an aborted transfer is
      // reported to the host as NXM.
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_ack   <= (r_state != S_IDLE);
      r_nxm   <= (r_state != S_IDLE);
      r_daltx <= 1'b0;
      r_tdmr  <= 1'b0;
      r_tsack <= 1'b0;
      r_tdmgo <= 1'b0;
      r_tsync <= 1'b0;
      r_tdin  <= 1'b0;
      r_tdout <= 1'b0;
      r_tbs7  <= 1'b0;
      r_twtbt <= 1'b0;
`ifdef QDMA_HOLD_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      r_ack <= 1'b0;
      r_nxm <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_flag <= 1'b0;
`ifdef QDMA_HOLD_EN
          if (r_tsack) begin
            // TSACK still held from the previous transfer: only a req in
            // this (ack) clock may reuse the bus, otherwise let it go.
            r_tdmgo <= 1'b0;
            if (req) begin
              r_we       <= we;
              r_addr     <= addr[21:1];
              r_wdata    <= wdata;
              r_dal_out  <= {addr[21:1], 1'b0};
              r_tbs7     <= &addr[21:13];
              r_twtbt    <= we;
              r_daltx    <= 1'b1;
              r_hold_cnt <= r_hold_cnt + 3'd1;
              r_state    <= S_ADDR;
            end else begin
              r_tsack    <= 1'b0;
              r_hold_cnt <= '0;
            end
          end else
`endif
          if (req) begin
            r_we    <= we;
            r_addr  <= addr[21:1];
            r_wdata <= wdata;
            r_tdmr  <= 1'b1;
            r_tdmgo <= 1'b0;
            r_state <= S_ARB;
          end else begin
            r_tdmgo <= RDMGI;
          end
        end

        S_ARB: begin
          if (RDMGI) begin
            r_tdmr  <= 1'b0;
            r_tsack <= 1'b1;
            r_state <= S_WAITBUS;
          end else if (r_cnt == L_NXM_LAST) begin
            r_tdmr  <= 1'b0;
            r_flag  <= 1'b1;
            r_state <= S_REL;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_WAITBUS: begin
          if (!RSYNC && !RRPLY) begin
            r_cnt     <= '0;
            r_dal_out <= {r_addr, 1'b0};
            r_tbs7    <= &r_addr[21:13];
            r_twtbt   <= r_we;
            r_daltx   <= 1'b1;
`ifdef QDMA_HOLD_EN
            r_hold_cnt <= 3'd1;
`endif
            r_state   <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (r_cnt == L_ADDR_LAST) begin
            r_cnt   <= '0;
            r_tsync <= 1'b1;
            r_state <= S_ASYNC;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_ASYNC: begin
          if (r_cnt == L_DATA_LAST) begin
            r_cnt   <= '0;
            r_tbs7  <= 1'b0;
            r_twtbt <= 1'b0;
            if (r_we) begin
              r_dal_out <= {6'd0, r_wdata};
              r_state   <= S_WR;
            end else begin
              // Release DAL on the same edge TDIN rises so they never overlap.
              r_daltx <= 1'b0;
              r_tdin  <= 1'b1;
              r_state <= S_RD;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_RD: begin
          if (RRPLY) begin
            r_cnt   <= '0;
            r_state <= S_RDLY;
          end else if (r_cnt == L_NXM_LAST) begin
            r_flag  <= 1'b1;
            r_tdin  <= 1'b0;
            r_state <= S_FIN;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_RDLY: begin
          if (r_cnt == L_RDLY_LAST) begin
            r_rdata <= DAL[15:0];
            r_tdin  <= 1'b0;
            r_state <= S_FIN;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_WR: begin
          if (r_cnt == L_DATA_LAST) begin
            r_cnt   <= '0;
            r_tdout <= 1'b1;
            r_state <= S_DOUT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_DOUT: begin
          if (RRPLY) begin
            r_tdout <= 1'b0;
            r_state <= S_FIN;
          end else if (r_cnt == L_NXM_LAST) begin
            r_flag  <= 1'b1;
            r_tdout <= 1'b0;
            r_state <= S_FIN;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_FIN: begin
          r_tdin  <= 1'b0;
          r_tdout <= 1'b0;
          if (r_flag || !RRPLY) begin
            r_tsync <= 1'b0;
            r_daltx <= 1'b0;
            r_state <= S_REL;
          end
        end

        S_REL: begin
          r_ack   <= 1'b1;
          r_nxm   <= r_flag;
`ifdef QDMA_HOLD_EN
          r_tsack <= r_tsack && !r_flag && (r_hold_cnt < 3'd4);
`else
          r_tsack <= 1'b0;
`endif
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qbus_dma_master.sv
module tb_qbus_dma_master;

  localparam int unsigned ADDR_SETUP = 15;
  localparam int unsigned DATA_SETUP = 10;
  localparam int unsigned RPLY_DLY   = 15;
  localparam int unsigned NXM_TO     = 1000;

  localparam logic [21:0] IOREG = 22'o17777774;
  localparam logic [21:0] NOREG = 22'o17777770;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [21:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        ack, nxm;
  logic [15:0] rdata;
  wire  [21:0] DAL_w;
  logic        DALtx;
  logic        RSYNC = 1'b0;
  logic        RINIT = 1'b0;
  logic        TDMR, TSACK, TDMGO, TSYNC, TDIN, TDOUT, TBS7, TWTBT;

  // bus environment state
  logic        s_rply = 1'b0;
  logic        s_drv = 1'b0;
  logic        s_sel = 1'b0;
  logic        s_prev_sync = 1'b0;
  logic [21:0] s_addr = '0;
  logic [15:0] s_data = '0;
  logic [15:0] s_mem [logic [21:0]];
  logic        g_en = 1'b1;
  logic        g_dmgi = 1'b0;
  logic        f_dmgi = 1'b0;
  int unsigned g_wait = 0;
  logic        w_dmgi;

  // reference model
  logic [15:0] ref_mem [logic [21:0]];
  logic [15:0] exp_rdata = '0;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  assign DAL_w  = s_drv ? {6'd0, s_data} : 'z;
  assign w_dmgi = g_dmgi | f_dmgi;

  always #5 clk = ~clk;

  qbus_dma_master #(
    .ADDR_SETUP(ADDR_SETUP),
    .DATA_SETUP(DATA_SETUP),
    .RPLY_DLY  (RPLY_DLY),
    .NXM_TO    (NXM_TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .ack  (ack),
    .nxm  (nxm),
    .rdata(rdata),
    .DAL  (DAL_w),
    .DALtx(DALtx),
    .RSYNC(RSYNC),
    .RRPLY(s_rply),
    .RDMGI(w_dmgi),
    .RINIT(RINIT),
    .TDMR (TDMR),
    .TSACK(TSACK),
    .TDMGO(TDMGO),
    .TSYNC(TSYNC),
    .TDIN (TDIN),
    .TDOUT(TDOUT),
    .TBS7 (TBS7),
    .TWTBT(TWTBT)
  );

  function automatic logic present(input logic [21:0] a);
    return (a == IOREG) || (a < 22'h001000);
  endfunction

  function automatic logic [15:0] init_val(input logic [21:0] a);
    return (a == IOREG) ? 16'o123456 : (a[16:1] ^ 16'hA5A5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Bus slave (memory below 0x1000 plus one I/O register) and DMA arbiter.
  always @(negedge clk) begin
    if (TSYNC && !s_prev_sync) begin
      s_addr = DAL_w;
      s_sel  = present(DAL_w);
    end
    if (!TSYNC) s_sel = 1'b0;
    s_prev_sync = TSYNC;
    if (s_sel && TDIN) begin
      s_data = s_mem.exists(s_addr) ? s_mem[s_addr] : init_val(s_addr);
      s_drv  = 1'b1;
      s_rply = 1'b1;
    end else if (s_sel && TDOUT) begin
      if (!s_rply) s_mem[s_addr] = DAL_w[15:0];
      s_rply = 1'b1;
    end else begin
      s_drv  = 1'b0;
      s_rply = 1'b0;
    end

    if (g_en && TDMR && !TSACK) begin
      if (g_wait == 0) g_dmgi = 1'b1;
      else g_wait--;
    end else begin
      g_dmgi = 1'b0;
      g_wait = $urandom_range(0, 5);
    end
  end

  // Edge timestamps and protocol monitors.
  int unsigned cyc = 0;
  int unsigned t_daltx_r = 0, t_sync_r = 0, t_bs7_f = 0, t_wt_f = 0, t_dout_r = 0;
  int unsigned t_din_r = 0, t_din_f = 0, t_dmr_r = 0, t_dmr_f = 0;
  int unsigned v_excl = 0, v_wtbt = 0, v_grant = 0;
  logic bs7_at_sync = 1'b0, wt_at_sync = 1'b0;
  logic p_daltx = 1'b0, p_sync = 1'b0, p_bs7 = 1'b0, p_wt = 1'b0;
  logic p_dout = 1'b0, p_din = 1'b0, p_dmr = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (DALtx && !p_daltx) t_daltx_r = cyc;
    if (TSYNC && !p_sync) begin
      t_sync_r    = cyc;
      bs7_at_sync = TBS7;
      wt_at_sync  = TWTBT;
    end
    if (!TBS7 && p_bs7)   t_bs7_f  = cyc;
    if (!TWTBT && p_wt)   t_wt_f   = cyc;
    if (TDOUT && !p_dout) t_dout_r = cyc;
    if (TDIN && !p_din)   t_din_r  = cyc;
    if (!TDIN && p_din)   t_din_f  = cyc;
    if (TDMR && !p_dmr)   t_dmr_r  = cyc;
    if (!TDMR && p_dmr)   t_dmr_f  = cyc;
    if (DALtx && TDIN) v_excl++;
    if (TWTBT && (TDIN || TDOUT)) v_wtbt++;
    if (TDMGO && TDMR) v_grant++;
    p_daltx = DALtx; p_sync = TSYNC; p_bs7 = TBS7; p_wt = TWTBT;
    p_dout = TDOUT; p_din = TDIN; p_dmr = TDMR;
  end

  task automatic xfer(input logic w, input logic [21:0] a, input logic [15:0] d,
                      output logic got_ack, output logic got_nxm);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    got_ack = 1'b0;
    got_nxm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (ack) begin
        got_ack = 1'b1;
        got_nxm = nxm;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One transfer checked against the model: every even address that has a
  // slave answers; anything else (or no grant) ends in NXM with rdata kept.
  task automatic run(input logic w, input logic [21:0] a, input logic [15:0] d);
    logic ga, gn, ok;
    logic [21:0] ea;
    ea = {a[21:1], 1'b0};
    ok = present(ea) && g_en;
    xfer(w, a, d, ga, gn);
    chk("ack", 32'(ga), 32'd1);
    chk("nxm", 32'(gn), 32'(!ok));
    if (ok) begin
      if (w) ref_mem[ea] = d;
      else exp_rdata = ref_mem.exists(ea) ? ref_mem[ea] : init_val(ea);
    end
    chk("rdata", 32'(rdata), 32'(exp_rdata));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({ack, nxm, DALtx, TDMR, TSACK, TDMGO, TSYNC, TDIN, TDOUT, TBS7, TWTBT}), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // grant pass-through while idle
    f_dmgi = 1'b1;
    repeat (2) @(negedge clk);
    chk("tdmgo_pass", 32'(TDMGO), 32'd1);
    f_dmgi = 1'b0;
    repeat (2) @(negedge clk);
    chk("tdmgo_clear", 32'(TDMGO), 32'd0);

    // I/O page read
    run(1'b0, IOREG, 16'd0);
    chk("rd_tsack_rel", 32'(TSACK), 32'd0);
    chk("rd_addr_setup", t_sync_r - t_daltx_r, ADDR_SETUP);
    chk("rd_bs7", 32'(bs7_at_sync), 32'd1);
    chk("rd_addr_hold", t_bs7_f - t_sync_r, DATA_SETUP);

    // write then read back
    run(1'b1, IOREG, 16'o054321);
    chk("wr_twtbt", 32'(wt_at_sync), 32'd1);
    chk("wr_addr_setup", t_sync_r - t_daltx_r, ADDR_SETUP);
    chk("wr_data_setup", t_dout_r - t_wt_f, DATA_SETUP);
    run(1'b0, IOREG, 16'd0);

    // no slave: RD timeout
    run(1'b0, NOREG, 16'd0);
    chk("nxm_rd_time", t_din_f - t_din_r, NXM_TO);
    chk("nxm_released", 32'({TSACK, TSYNC, DALtx}), 32'd0);

    // no grant: ARB timeout
    g_en = 1'b0;
    run(1'b0, IOREG, 16'd0);
    chk("arb_time", t_dmr_f - t_dmr_r, NXM_TO);
    g_en = 1'b1;

    // RINIT in RDLY
    begin
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 22'h000010;
      @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(posedge clk);
        #1;
        if (s_rply && TDIN) begin
          seen = 1'b1;
          break;
        end
      end
      chk("rinit_reach_rdly", 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      RINIT = 1'b1;
      @(negedge clk);
      chk("rinit_drop", 32'({DALtx, TDMR, TSACK, TDMGO, TSYNC, TDIN, TDOUT, TBS7, TWTBT}), 32'd0);
      chk("rinit_ack", 32'({ack, nxm}), 32'b11);
      chk("rinit_rdata", 32'(rdata), 32'(exp_rdata));
      RINIT = 1'b0;
      repeat (3) @(negedge clk);
    end
    run(1'b0, IOREG, 16'd0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int unsigned c;
      logic [21:0] a;
      c = $urandom_range(0, 9);
      if (c < 3)       a = IOREG | 22'($urandom_range(0, 1));
      else if (c < 8)  a = 22'($urandom_range(0, 63));
      else if (c == 8) a = NOREG;
      else             a = 22'h200000 | 22'($urandom_range(0, 65535));
      run(1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    chk("excl_daltx_tdin", v_excl, 32'd0);
    chk("twtbt_addr_only", v_wtbt, 32'd0);
    chk("no_grant_pass_busy", v_grant, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/qbus_dma_master.md
Name: qbus_dma_master

Overview:
Bus-master sequencer for the QBUS interface. It turns single-word host requests into correctly timed DATI (read) and DATO (write) cycles on the FPGA side of the QBUS drivers. It handles DMR/DMG/SACK arbitration, the address/data setup windows, the RPLY data-latch delay, and NXM timeout. It sits beside the register slaves on the shared DAL/DALtx lines and supplies DMA for disk/controller logic.

Parameters:
ADDR_SETUP, 15, clocks DAL/BS7 driven before TSYNC asserts (150 ns at 10 ns clk)
DATA_SETUP, 10, clocks write data driven before TDOUT; also address hold after TSYNC
RPLY_DLY, 15, clocks from first RRPLY seen to rdata latch on reads
NXM_TO, 1000, clocks waiting for RRPLY (or RDMGI) before declaring NXM

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  1  host request; sampled in IDLE only
we  input  1  1=DATO write, 0=DATI read; captured with req
addr  input  22  byte address; bit 0 ignored (forced 0 on DAL)
wdata  input  16  write data; captured with req
ack  output  1  one-clock pulse: transfer finished (ok or NXM)
nxm  output  1  valid with ack; 1 = no RPLY or no grant within NXM_TO
rdata  output  16  read data; holds last latched value
DAL  inout  22  shared data/address lines; driven only while DALtx=1, else high-Z
DALtx  output  1  DAL driver direction (wor with slaves)
RSYNC  input  1  bus SYNC as seen by FPGA, active-high
RRPLY  input  1  bus RPLY, active-high
RDMGI  input  1  DMA grant in
RINIT  input  1  bus init
TDMR  output  1  DMA request
TSACK  output  1  select acknowledge (bus ownership)
TDMGO  output  1  grant passed downstream
TSYNC  output  1  master SYNC
TDIN  output  1  master DIN
TDOUT  output  1  master DOUT
TBS7  output  1  I/O page strobe
TWTBT  output  1  write/byte strobe (address phase only, word writes)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. On reset all T* outputs, DALtx, ack and nxm go 0, rdata goes 0, and the FSM enters IDLE.
- States: IDLE, ARB, WAITBUS, ADDR, ASYNC, RD, RDLY, WR, DOUT, FIN, REL.
- IDLE: when req=1, capture we/addr/wdata and go to ARB.
- ARB: TDMR=1. On RDMGI=1, go to WAITBUS. If NXM_TO expires, go to REL with nxm.
- WAITBUS: TSACK=1, TDMR=0. Once RSYNC=0 and RRPLY=0 in the same clock, go to ADDR.
- ADDR: DALtx=1, DAL={addr[21:1],0}, TBS7=(addr[21:13]==all ones), TWTBT=we. Hold ADDR_SETUP clocks, then go to ASYNC.
- ASYNC: TSYNC=1, held through FIN. Keep the address DATA_SETUP clocks. Then TBS7=0 and TWTBT=0. Reads: DALtx=0 and go to RD. Writes: DAL=wdata (upper bits 0) and go to WR.
- RD: TDIN=1. On the first clock RRPLY=1, go to RDLY.
- RDLY: wait RPLY_DLY clocks, then rdata=DAL[15:0] and go to FIN.
- WR: hold data DATA_SETUP clocks, then go to DOUT.
- DOUT: TDOUT=1. When RRPLY=1, go to FIN.
- NXM timeout: the counter restarts on entry to ARB, RD and DOUT. Hitting NXM_TO in RD or DOUT goes to FIN with the NXM flag set; rdata is unchanged.
- FIN: TDIN=0 and TDOUT=0. Wait RRPLY=0 (skip the wait on NXM), then TSYNC=0, DALtx=0, go to REL.
- REL: TSACK=0, ack=1 for one clock, nxm=flag, then IDLE.
- TDMGO=RDMGI whenever the FSM is in IDLE (not requesting). It is 0 in all other states, so the grant is never passed on while this block is requesting.
- RINIT=1 in any state: same-clock return to IDLE with all T* and DALtx dropped. If the FSM was not in IDLE, pulse ack with nxm=1.
- DAL is never driven while TSYNC=0 except in ADDR. DALtx and TDIN are never both 1.
- Counters are 16 bits wide and saturate; they do not wrap.

Optional Feature:
QDMA_HOLD_EN: when defined, a req=1 present in the clock ack pulses keeps TSACK asserted and goes straight to ADDR, skipping ARB and WAITBUS. This allows at most 4 consecutive held transfers, after which REL is taken normally. When undefined, every transfer re-arbitrates from ARB.

Test Plan:
- Read 17777774 (register slave holding 123456): TDMR, grant, then TBS7=1 with ADDR_SETUP before TSYNC -> ack with nxm=0, rdata=0o123456, TSACK=0 after ack.
- Write 0o054321 to 17777774, then read it back -> TWTBT=1 only in the address phase, TDOUT follows data by DATA_SETUP; readback gives rdata=0o054321.
- Read 17777770 (no slave) -> no RRPLY; after NXM_TO clocks in RD, ack with nxm=1, rdata unchanged, bus released.
- Hold RDMGI=0 with req=1 -> ARB times out at NXM_TO, ack with nxm=1. With no req, RDMGI=1 passes through -> TDMGO=1.
- Assert RINIT during RDLY -> same clock all T*=0 and DALtx=0, ack with nxm=1; the next req completes normally.
- With QDMA_HOLD_EN defined, issue 6 back-to-back reads -> TSACK stays high for 4 transfers, then drops, then TDMR re-asserts for the remaining 2.
